// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: 8x8 -> 16-bit multiply sequenced over four nibble steps on one shared 4x4 multiplier.
// Optional macro MULT_SEQ_SIGNED_EN: two's-complement operands (magnitudes multiplied, sign applied at the end).
module mult_seq_ctrl #(
  parameter int DONE_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clear,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic [15:0] product,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_code
);

  // Encoding doubles as the 7-segment code, so it must not be re-encoded.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP0 = 3'd1,
    STEP1 = 3'd2,
    STEP2 = 3'd3,
    STEP3 = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam int CNT_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((DONE_HOLD > 0) ? DONE_HOLD - 1 : 0);

  state_t           state_q;
  logic [7:0]       a_q, b_q;
  logic [15:0]      acc_q, product_q;
  logic             valid_q, done_q;
  logic [CNT_W-1:0] hold_q;

  logic [15:0]      partial, acc_d, final_d;
  logic [7:0]       a_in, b_in;

`ifdef MULT_SEQ_SIGNED_EN
  logic sign_q;
  // 0x80 negates to itself, which is exactly 128 when read as unsigned.
  assign a_in    = dataa[7] ? (~dataa + 8'd1) : dataa;
  assign b_in    = datab[7] ? (~datab + 8'd1) : datab;
  assign final_d = sign_q ? (~acc_d + 16'd1) : acc_d;
`else
  assign a_in    = dataa;
  assign b_in    = datab;
  assign final_d = acc_d;
`endif

  always_comb begin
    mul_a   = 4'd0;
    mul_b   = 4'd0;
    partial = 16'd0;
    case (state_q)
      STEP0: begin
        mul_a   = a_q[3:0];
        mul_b   = b_q[3:0];
        partial = {8'd0, mul_p};
      end
      STEP1: begin
        mul_a   = a_q[7:4];
        mul_b   = b_q[3:0];
        partial = {4'd0, mul_p, 4'd0};
      end
      STEP2: begin
        mul_a   = a_q[3:0];
        mul_b   = b_q[7:4];
        partial = {4'd0, mul_p, 4'd0};
      end
      STEP3: begin
        mul_a   = a_q[7:4];
        mul_b   = b_q[7:4];
        partial = {mul_p, 8'd0};
      end
      default: ;
    endcase
  end

  assign acc_d = acc_q + partial;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      acc_q     <= 16'd0;
      product_q <= 16'd0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      hold_q    <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state_q   <= IDLE;
        acc_q     <= 16'd0;
        product_q <= 16'd0;
        valid_q   <= 1'b0;
        hold_q    <= '0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start) begin
              a_q     <= a_in;
              b_q     <= b_in;
`ifdef MULT_SEQ_SIGNED_EN
              sign_q  <= dataa[7] ^ datab[7];
`endif
              acc_q   <= 16'd0;
              valid_q <= 1'b0;
              state_q <= STEP0;
            end else if (state_q == DONE && DONE_HOLD != 0) begin
              if (hold_q == HOLD_LAST) state_q <= IDLE;
              else                     hold_q  <= hold_q + CNT_W'(1);
            end
          end
          STEP0, STEP1, STEP2, STEP3: begin
            if (start) begin
              // A start while busy is a protocol violation: discard everything.
              state_q   <= ERR;
              acc_q     <= 16'd0;
              product_q <= 16'd0;
              valid_q   <= 1'b0;
            end else begin
              acc_q <= acc_d;
              case (state_q)
                STEP0:   state_q <= STEP1;
                STEP1:   state_q <= STEP2;
                STEP2:   state_q <= STEP3;
                default: begin
                  product_q <= final_d;
                  valid_q   <= 1'b1;
                  done_q    <= 1'b1;
                  hold_q    <= '0;
                  state_q   <= DONE;
                end
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign product    = product_q;
  assign valid      = valid_q;
  assign done       = done_q;
  assign busy       = (state_q == STEP0) || (state_q == STEP1) ||
                      (state_q == STEP2) || (state_q == STEP3);
  assign state_code = state_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Testbench for mult_seq_ctrl: directed scenarios plus randomized operations against an arithmetic reference.
module tb_mult_seq_ctrl;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset, start, clear;
  logic [7:0]  dataa, datab;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;
  logic [15:0] product;
  logic        valid, busy, done;
  logic [2:0]  state_code;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_prod;
  logic        exp_valid;

  always #5 clk = ~clk;

  // Stand-in for the shared 4x4 multiplier on the board.
  assign mul_p = {4'd0, mul_a} * {4'd0, mul_b};

  mult_seq_ctrl #(.DONE_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .dataa(dataa), .datab(datab), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .product(product), .valid(valid), .busy(busy), .done(done), .state_code(state_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
`ifdef MULT_SEQ_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'(a);
    sb = int'(b);
`endif
    return 16'(sa * sb);
  endfunction

  function automatic logic [7:0] mag(input logic [7:0] v);
`ifdef MULT_SEQ_SIGNED_EN
    if (v[7]) return 8'(128 - int'(v[6:0]));
`endif
    return v;
  endfunction

  // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge of STEP0.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    dataa = a;
    datab = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dataa = 8'($urandom);
    datab = 8'($urandom);
  endtask

  task automatic check_step(input int k, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ma, mb;
    ma = mag(a);
    mb = mag(b);
    check("step_code", state_code, k + 1);
    check("step_busy", busy, 1);
    check("step_valid", valid, 0);
    check("step_done", done, 0);
    check("step_mul_a", mul_a, (k == 0 || k == 2) ? ma[3:0] : ma[7:4]);
    check("step_mul_b", mul_b, (k < 2) ? mb[3:0] : mb[7:4]);
  endtask

  // From STEP0 negedge through to the first DONE negedge.
  task automatic finish_mult(input logic [7:0] a, input logic [7:0] b);
    for (int k = 0; k < 4; k++) begin
      check_step(k, a, b);
      @(negedge clk);
    end
    exp_prod  = ref_prod(a, b);
    exp_valid = 1'b1;
    check("done_pulse", done, 1);
    check("done_code", state_code, 5);
    check("done_busy", busy, 0);
    check("done_product", product, exp_prod);
    check("done_valid", valid, 1);
    check("done_mul_a", mul_a, 0);
    $display("MULT a=%02h b=%02h product=%04h", a, b, product);
  endtask

  task automatic wait_idle();
    for (int i = 1; i < HOLD; i++) begin
      @(negedge clk);
      check("hold_code", state_code, 5);
      check("hold_done", done, 0);
    end
    @(negedge clk);
    check("idle_code", state_code, 0);
    check("idle_product", product, exp_prod);
    check("idle_valid", valid, exp_valid);
    @(negedge clk);
    check("idle_keep_code", state_code, 0);
    check("idle_keep_product", product, exp_prod);
  endtask

  task automatic abort_op(input logic [7:0] a, input logic [7:0] b, input int k);
    start_op(a, b);
    for (int j = 0; j < k; j++) begin
      check_step(j, a, b);
      @(negedge clk);
    end
    check_step(k, a, b);
    start = 1'b1;
    dataa = 8'($urandom);
    @(negedge clk);
    check("err_code", state_code, 6);
    check("err_valid", valid, 0);
    check("err_product", product, 0);
    check("err_busy", busy, 0);
    check("err_done", done, 0);
    check("err_mul_a", mul_a, 0);
    @(negedge clk);
    start = 1'b0;
    check("err_ignore_start", state_code, 6);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_prod  = 16'd0;
    exp_valid = 1'b0;
    check("err_clear_code", state_code, 0);
    check("err_clear_product", product, 0);
    $display("ABORT a=%02h b=%02h at step %0d", a, b, k);
  endtask

  task automatic clear_op(input logic [7:0] a, input logic [7:0] b, input int k);
    start_op(a, b);
    for (int j = 0; j < k; j++) begin
      check_step(j, a, b);
      @(negedge clk);
    end
    check_step(k, a, b);
    clear = 1'b1;
    start = 1'($urandom_range(0, 1));
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    exp_prod  = 16'd0;
    exp_valid = 1'b0;
    check("clr_code", state_code, 0);
    check("clr_product", product, 0);
    check("clr_valid", valid, 0);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    @(negedge clk);
    check("clr_stay_idle", state_code, 0);
    $display("CLEAR a=%02h b=%02h at step %0d", a, b, k);
  endtask

  task automatic clear_idle();
    clear = 1'b1;
    start = 1'($urandom_range(0, 1));
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    exp_prod  = 16'd0;
    exp_valid = 1'b0;
    check("clri_code", state_code, 0);
    check("clri_product", product, 0);
    check("clri_valid", valid, 0);
    @(negedge clk);
    check("clri_stay_idle", state_code, 0);
    $display("CLEAR idle");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a, b;
    int op;
    reset = 1'b1; start = 1'b0; clear = 1'b0; dataa = 8'd0; datab = 8'd0;
    exp_prod = 16'd0; exp_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_code", state_code, 0);
    check("rst_product", product, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    reset = 1'b0;
    @(negedge clk);

    // 0x12 * 0x34
    start_op(8'h12, 8'h34);
    finish_mult(8'h12, 8'h34);
    check("t2_product", product, 16'h03A8);
    wait_idle();

    // 0xFF * 0xFF, then hold to IDLE
    start_op(8'hFF, 8'hFF);
    finish_mult(8'hFF, 8'hFF);
`ifndef MULT_SEQ_SIGNED_EN
    check("t3_product", product, 16'hFE01);
`endif
    wait_idle();

    // Asynchronous reset in the middle of STEP2
    start_op(8'hFF, 8'hFF);
    check_step(0, 8'hFF, 8'hFF);
    @(negedge clk);
    check_step(1, 8'hFF, 8'hFF);
    @(negedge clk);
    check_step(2, 8'hFF, 8'hFF);
    reset = 1'b1;
    #1;
    check("t1_code", state_code, 0);
    check("t1_product", product, 0);
    check("t1_valid", valid, 0);
    check("t1_busy", busy, 0);
    check("t1_mul_a", mul_a, 0);
    check("t1_mul_b", mul_b, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_prod = 16'd0; exp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_no_done", done, 0);
      check("t1_idle", state_code, 0);
    end
    $display("RESET mid-STEP2");

    // Abort in STEP1, then restart from DONE with a zero operand
    abort_op(8'h5A, 8'hC3, 1);
    start_op(8'h21, 8'h43);
    finish_mult(8'h21, 8'h43);
    start_op(8'h00, 8'hAB);
    finish_mult(8'h00, 8'hAB);
    check("t5_product", product, 16'h0000);
    wait_idle();

`ifdef MULT_SEQ_SIGNED_EN
    start_op(8'hFE, 8'h03);
    finish_mult(8'hFE, 8'h03);
    check("t6_neg", product, 16'hFFFA);
    start_op(8'h80, 8'h80);
    finish_mult(8'h80, 8'h80);
    check("t6_minmin", product, 16'h4000);
    start_op(8'h80, 8'h01);
    finish_mult(8'h80, 8'h01);
    check("t6_min_one", product, 16'hFF80);
    wait_idle();
`endif

    for (int it = 0; it < 40; it++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      if (it % 5 == 0) a = (it % 10 == 0) ? 8'h80 : 8'hFF;
      op = $urandom_range(0, 4);
      case (op)
        0: begin start_op(a, b); finish_mult(a, b); wait_idle(); end
        1: begin start_op(a, b); finish_mult(a, b); end
        2: abort_op(a, b, $urandom_range(0, 3));
        3: clear_op(a, b, $urandom_range(0, 3));
        default: clear_idle();
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
